// File: rtl/hbm_wt_pkg.sv
// rtl/hbm_wt_pkg.sv - shared constants, FSM encoding and beat-count helpers
package hbm_wt_pkg;

  localparam int unsigned PAGE_BYTES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RUN,
    ST_DRAIN
  } fsm_state_e;

  function automatic int unsigned group_wt_beats(input int unsigned tgroup,
                                                 input int unsigned wt_dw,
                                                 input int unsigned dw);
    return tgroup * wt_dw / dw;
  endfunction

  // one scale beat per (possibly partial) group plus all weight beats
  function automatic int unsigned row_beat_count(input int unsigned chin,
                                                 input int unsigned tgroup,
                                                 input int unsigned wt_dw,
                                                 input int unsigned dw);
    return (chin + tgroup - 1) / tgroup + chin * wt_dw / dw;
  endfunction

endpackage

// File: rtl/hbm_burst_split.sv
// rtl/hbm_burst_split.sv - splits each row into AR bursts bounded by burst size, row end and 4 KB pages
module hbm_burst_split
  import hbm_wt_pkg::*;
#(
  parameter int DW        = 256,
  parameter int AW        = 32,
  parameter int CW        = 16,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] row_stride,
  input  logic [CW:0]   row_beats,
  input  logic [CW-1:0] rows,
  input  logic          can_issue,
  output logic          arvalid,
  input  logic          arready,
  output logic [AW-1:0] araddr,
  output logic [7:0]    arlen,
  output logic          last_ar
);

  localparam int LB  = $clog2(DW / 8);
  localparam int PB  = $clog2(PAGE_BYTES);
  localparam int PBW = PB - LB + 1;

  logic            active;
  logic [AW-1:0]   row_addr;
  logic [AW-1:0]   cur_addr;
  logic [CW:0]     rem;
  logic [CW-1:0]   row_idx;
  logic [PBW-1:0]  page_beats;
  logic [CW:0]     len;
  logic            hs;
  logic            row_end;

  always_comb begin
    page_beats = PBW'(PAGE_BYTES / (DW / 8)) - PBW'(cur_addr[PB-1:LB]);
    len = rem;
    if (len > (CW+1)'(MAX_BURST)) len = (CW+1)'(MAX_BURST);
    if ((CW+1)'(page_beats) < len) len = (CW+1)'(page_beats);
  end

  // address and length only move on a handshake, so they stay stable while stalled
  assign arvalid = active && can_issue;
  assign araddr  = cur_addr;
  assign arlen   = 8'(len - (CW+1)'(1));
  assign hs      = arvalid && arready;
  assign row_end = (rem == len);
  assign last_ar = hs && row_end && (row_idx == rows - CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active   <= 1'b0;
      row_addr <= '0;
      cur_addr <= '0;
      rem      <= '0;
      row_idx  <= '0;
    end else if (init) begin
      active   <= 1'b1;
      row_addr <= base_addr;
      cur_addr <= base_addr;
      rem      <= row_beats;
      row_idx  <= '0;
    end else if (hs) begin
      if (row_end) begin
        if (row_idx == rows - CW'(1)) begin
          active <= 1'b0;
        end else begin
          row_idx  <= row_idx + CW'(1);
          row_addr <= row_addr + row_stride;
          cur_addr <= row_addr + row_stride;
          rem      <= row_beats;
        end
      end else begin
        cur_addr <= cur_addr + (AW'(len) << LB);
        rem      <= rem - len;
      end
    end
  end

endmodule

// File: rtl/hbm_wt_group_fetch.sv
// rtl/hbm_wt_group_fetch.sv - HBM weight fetch with per-quant-group scale beat tagging
module hbm_wt_group_fetch
  import hbm_wt_pkg::*;
#(
  parameter int DW              = 256,
  parameter int WT_DW           = 4,
  parameter int WT_CH_TGROUP    = 2048,
  parameter int AW              = 32,
  parameter int CW              = 16,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] chin_pad,
  input  logic [CW-1:0] rows,
  input  logic [AW-1:0] row_stride,
  output logic          arvalid,
  input  logic          arready,
  output logic [AW-1:0] araddr,
  output logic [7:0]    arlen,
  output logic [2:0]    arsize,
  output logic [1:0]    arburst,
  input  logic          rvalid,
  output logic          rready,
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    rresp,
  input  logic          rlast,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_is_scale,
  output logic [CW-1:0] out_group,
  output logic          out_row_last,
  output logic          out_last,
  output logic          done,
  output logic          err_cfg,
  output logic          err_resp
);

  localparam int LB  = $clog2(DW / 8);
  localparam int GWB = int'(group_wt_beats(WT_CH_TGROUP, WT_DW, DW));
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  fsm_state_e    state, state_nxt;
  logic [AW-1:0] base_q, stride_q;
  logic [CW-1:0] chin_q, rows_q;
  logic [31:0]   chin_w, n_full, lc, last_wb, n_groups, cur_wb;
  logic [CW:0]   row_beats;
  logic          cfg_bad, cfg_empty;
  logic [CW-1:0] beat_in_grp, grp, row_idx;
  logic [OW-1:0] outstanding;
  logic          is_scale_raw, row_last_raw, last_raw;
  logic          out_hs, ar_hs, r_end, last_ar, can_issue, tagging;
  logic          split_init, done_set, cfg_err_set;

  assign out_valid = rvalid;
  assign rready    = out_ready;
  assign out_data  = rdata;
  assign arsize    = 3'(LB);
  assign arburst   = 2'b01;
  assign busy      = (state != ST_IDLE);
  assign tagging   = (state == ST_RUN) || (state == ST_DRAIN);
  assign out_hs    = rvalid && out_ready;
  assign ar_hs     = arvalid && arready;
  assign r_end     = out_hs && rlast;
  assign can_issue = (outstanding < OW'(MAX_OUTSTANDING));

  always_comb begin
    chin_w    = 32'(chin_q);
    n_full    = chin_w / 32'(WT_CH_TGROUP);
    lc        = chin_w % 32'(WT_CH_TGROUP);
    last_wb   = lc * 32'(WT_DW) / 32'(DW);
    n_groups  = n_full + ((lc != 32'd0) ? 32'd1 : 32'd0);
    row_beats = (CW+1)'(row_beat_count(chin_w, WT_CH_TGROUP, WT_DW, DW));
    cfg_bad   = (((chin_w * 32'(WT_DW)) % 32'(DW)) != 32'd0)
                || (base_q[LB-1:0] != '0) || (stride_q[LB-1:0] != '0);
    cfg_empty = (rows_q == '0) || (chin_q == '0);
  end

  // only the trailing partial group (grp == n_full) has a short weight run
  always_comb begin
    cur_wb       = (32'(grp) == n_full) ? last_wb : 32'(GWB);
    is_scale_raw = (32'(beat_in_grp) == cur_wb);
    row_last_raw = is_scale_raw && (32'(grp) == n_groups - 32'd1);
    last_raw     = row_last_raw && (row_idx == rows_q - CW'(1));
  end

  assign out_is_scale = tagging && is_scale_raw;
  assign out_row_last = tagging && row_last_raw;
  assign out_last     = tagging && last_raw;
  assign out_group    = tagging ? grp : '0;

  hbm_burst_split #(
    .DW        (DW),
    .AW        (AW),
    .CW        (CW),
    .MAX_BURST (MAX_BURST)
  ) u_split (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (split_init),
    .base_addr  (base_q),
    .row_stride (stride_q),
    .row_beats  (row_beats),
    .rows       (rows_q),
    .can_issue  (can_issue),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .arlen      (arlen),
    .last_ar    (last_ar)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    split_init  = 1'b0;
    done_set    = 1'b0;
    cfg_err_set = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (cfg_bad) begin
          cfg_err_set = 1'b1;
          done_set    = 1'b1;
          state_nxt   = ST_IDLE;
        end else if (cfg_empty) begin
          done_set  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          split_init = 1'b1;
          state_nxt  = ST_RUN;
        end
      end
      ST_RUN:   if (last_ar) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (out_hs && last_raw) begin
          done_set  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q      <= '0;
      stride_q    <= '0;
      chin_q      <= '0;
      rows_q      <= '0;
      done        <= 1'b0;
      err_cfg     <= 1'b0;
      err_resp    <= 1'b0;
      outstanding <= '0;
    end else begin
      done <= done_set;
      if (state == ST_IDLE && start) begin
        base_q   <= base_addr;
        stride_q <= row_stride;
        chin_q   <= chin_pad;
        rows_q   <= rows;
        err_cfg  <= 1'b0;
        err_resp <= 1'b0;
      end else begin
        if (cfg_err_set) err_cfg <= 1'b1;
        if (out_hs && tagging && rresp != 2'b00) err_resp <= 1'b1;
      end
      // a simultaneous issue and burst completion cancel out
      case ({ar_hs, r_end})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_in_grp <= '0;
      grp         <= '0;
      row_idx     <= '0;
    end else if (state == ST_IDLE && start) begin
      beat_in_grp <= '0;
      grp         <= '0;
      row_idx     <= '0;
    end else if (out_hs && tagging) begin
      if (is_scale_raw) begin
        beat_in_grp <= '0;
        if (row_last_raw) begin
          grp     <= '0;
          row_idx <= row_idx + CW'(1);
        end else begin
          grp <= grp + CW'(1);
        end
      end else begin
        beat_in_grp <= beat_in_grp + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hbm_wt_group_fetch.sv
// tb/tb_hbm_wt_group_fetch.sv - scoreboard bench for hbm_wt_group_fetch with an AXI read responder
module tb_hbm_wt_group_fetch;

  localparam int DW = 256;
  localparam int AW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] chin_pad = '0;
  logic [CW-1:0] rows = '0;
  logic [AW-1:0] row_stride = '0;
  logic          arvalid;
  logic          arready = 1'b1;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = '0;
  logic          rlast = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_is_scale;
  logic [CW-1:0] out_group;
  logic          out_row_last;
  logic          out_last;
  logic          done;
  logic          err_cfg;
  logic          err_resp;

  hbm_wt_group_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .base_addr(base_addr), .chin_pad(chin_pad), .rows(rows), .row_stride(row_stride),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_is_scale(out_is_scale), .out_group(out_group),
    .out_row_last(out_row_last), .out_last(out_last),
    .done(done), .err_cfg(err_cfg), .err_resp(err_resp)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [DW-1:0] data; logic sc; logic [CW-1:0] grp; logic rl; logic last; } beat_t;
  typedef struct { logic [AW-1:0] addr; logic last; } rbeat_t;

  ar_t    exp_ar[$], obs_ar[$];
  beat_t  exp_beat[$], obs_beat[$];
  rbeat_t pend[$];

  int     n_vec = 0, n_fail = 0;
  longint cyc = 0, last_cyc = 0;
  int     outst = 0, max_outst = 0, acc_cnt = 0, err_beat = -1;
  bit     stall = 1'b0;
  bit     hold_ar = 1'b0;
  ar_t    held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // AXI slave: in-order R beats whose payload is the beat byte address
  always begin
    @(negedge clk);
    if (!rst_n) begin
      pend.delete();
      outst   = 0;
      hold_ar = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rresp   = 2'b00;
      rdata   = '0;
    end else begin
      arready   = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      rvalid    = (pend.size() > 0);
      if (rvalid) begin
        rdata = DW'(pend[0].addr);
        rlast = pend[0].last;
        rresp = (acc_cnt == err_beat) ? 2'd2 : 2'd0;
      end else begin
        rdata = '0;
        rlast = 1'b0;
        rresp = 2'd0;
      end
      #2;
      if (hold_ar) begin
        check("ar_hold_valid", arvalid, 1);
        check("ar_hold_addr", araddr, held.addr);
        check("ar_hold_len", arlen, held.len);
      end
      hold_ar = arvalid && !arready;
      held    = '{addr: araddr, len: arlen};
      if (arvalid && arready) begin
        obs_ar.push_back('{addr: araddr, len: arlen});
        for (int i = 0; i <= int'(arlen); i++)
          pend.push_back('{addr: araddr + AW'(i * 32), last: (i == int'(arlen))});
        outst++;
      end
      if (rvalid && out_ready) begin
        void'(pend.pop_front());
        acc_cnt++;
        if (rlast) outst--;
      end
      if (outst > max_outst) max_outst = outst;
    end
  end

  always begin
    beat_t e;
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      obs_beat.push_back('{data: out_data, sc: out_is_scale, grp: out_group, rl: out_row_last, last: out_last});
      if (exp_beat.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = exp_beat.pop_front();
        check("beat_data", 64'(out_data === e.data), 1);
        check("beat_tags", 64'({out_is_scale, out_row_last, out_last, out_group}),
              64'({e.sc, e.rl, e.last, e.grp}));
        if (e.last) last_cyc = cyc;
      end
    end
  end

  function automatic logic [63:0] bf(input int i, input int f);
    if (i >= obs_beat.size()) return 'x;
    case (f)
      0:       return 64'(obs_beat[i].sc);
      1:       return 64'(obs_beat[i].grp);
      2:       return 64'(obs_beat[i].rl);
      default: return 64'(obs_beat[i].last);
    endcase
  endfunction

  function automatic logic [63:0] af(input int i, input int f);
    if (i >= obs_ar.size()) return 'x;
    if (f == 0) return 64'(obs_ar[i].addr);
    return 64'(obs_ar[i].len);
  endfunction

  function automatic int scale_count(input int n);
    int c = 0;
    for (int i = 0; i < n && i < obs_beat.size(); i++)
      if (obs_beat[i].sc) c++;
    return c;
  endfunction

  task automatic build_exp(input logic [AW-1:0] base, input int chin, input int nrows,
                           input logic [AW-1:0] stride);
    int nfull, lc, lwb, ng, rb, idx, nwb, n, rem, room;
    logic [AW-1:0] rbase, a;
    exp_ar.delete();
    exp_beat.delete();
    obs_ar.delete();
    obs_beat.delete();
    nfull = chin / 2048;
    lc    = chin % 2048;
    lwb   = lc * 4 / 256;
    ng    = nfull + ((lc != 0) ? 1 : 0);
    rb    = ng + chin * 4 / 256;
    for (int r = 0; r < nrows; r++) begin
      rbase = base + AW'(r) * stride;
      idx   = 0;
      for (int g = 0; g < ng; g++) begin
        nwb = (g < nfull) ? 32 : lwb;
        for (int k = 0; k < nwb; k++) begin
          exp_beat.push_back('{data: DW'(rbase + AW'(idx * 32)), sc: 1'b0, grp: CW'(g), rl: 1'b0, last: 1'b0});
          idx++;
        end
        exp_beat.push_back('{data: DW'(rbase + AW'(idx * 32)), sc: 1'b1, grp: CW'(g),
                             rl: (g == ng - 1), last: (g == ng - 1) && (r == nrows - 1)});
        idx++;
      end
      a   = rbase;
      rem = rb;
      while (rem > 0) begin
        room = (4096 - int'(a % 4096)) / 32;
        n = 16;
        if (rem < n) n = rem;
        if (room < n) n = room;
        exp_ar.push_back('{addr: a, len: 8'(n - 1)});
        a   = a + AW'(n * 32);
        rem = rem - n;
      end
    end
  endtask

  task automatic issue_start(input logic [AW-1:0] base, input int chin, input int nrows,
                             input logic [AW-1:0] stride);
    @(negedge clk);
    #1;
    base_addr  = base;
    chin_pad   = CW'(chin);
    rows       = CW'(nrows);
    row_stride = stride;
    start      = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_case(input string tag, input logic [AW-1:0] base, input int chin, input int nrows,
                          input logic [AW-1:0] stride, input bit stl, input int eb, input bit exp_cfg);
    bit     got;
    longint done_cyc;
    int     n_exp, n_ar;
    if (exp_cfg) build_exp(base, chin, 0, stride);
    else         build_exp(base, chin, nrows, stride);
    n_exp     = exp_beat.size();
    n_ar      = exp_ar.size();
    acc_cnt   = 0;
    err_beat  = eb;
    stall     = stl;
    max_outst = 0;
    issue_start(base, chin, nrows, stride);
    got      = 1'b0;
    done_cyc = 0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      #3;
      if (done) begin
        got      = 1'b1;
        done_cyc = cyc;
      end
    end
    check({tag, "_done_seen"}, 64'(got), 1);
    @(negedge clk);
    #3;
    check({tag, "_done_width"}, 64'(done), 0);
    check({tag, "_busy_after"}, 64'(busy), 0);
    check({tag, "_err_cfg"}, 64'(err_cfg), 64'(exp_cfg));
    check({tag, "_err_resp"}, 64'(err_resp), 64'(eb >= 0));
    check({tag, "_beats_left"}, 64'(exp_beat.size()), 0);
    check({tag, "_ar_count"}, 64'(obs_ar.size()), 64'(n_ar));
    for (int i = 0; i < n_ar && i < obs_ar.size(); i++) begin
      check({tag, "_ar_addr"}, 64'(obs_ar[i].addr), 64'(exp_ar[i].addr));
      check({tag, "_ar_len"}, 64'(obs_ar[i].len), 64'(exp_ar[i].len));
    end
    check({tag, "_max_outstanding_le4"}, 64'(max_outst <= 4), 1);
    if (n_exp > 0 && got) check({tag, "_done_latency"}, 64'(done_cyc - last_cyc), 1);
    stall = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    repeat (3) @(negedge clk);
    #3;
    check("rst_busy", 64'(busy), 0);
    check("rst_arvalid", 64'(arvalid), 0);
    check("rst_done", 64'(done), 0);
    check("rst_err", 64'({err_cfg, err_resp}), 0);
    check("rst_rready_follows", 64'(rready), 64'(out_ready));
    check("arsize", 64'(arsize), 5);
    check("arburst", 64'(arburst), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    run_case("c704", 32'h0, 704, 1, 32'h0, 1'b0, -1, 1'b0);
    check("c704_single_ar_len", af(0, 1), 11);
    check("c704_b11_scale", bf(11, 0), 1);
    check("c704_b11_rowlast", bf(11, 2), 1);
    check("c704_b11_last", bf(11, 3), 1);

    run_case("c4160", 32'h0, 4160, 2, 32'h1000, 1'b0, -1, 1'b0);
    check("c4160_scale32", bf(32, 0), 1);
    check("c4160_scale65", bf(65, 0), 1);
    check("c4160_scale67", bf(67, 0), 1);
    check("c4160_row0_scales", 64'(scale_count(68)), 3);
    check("c4160_grp_b10", bf(10, 1), 0);
    check("c4160_grp_b40", bf(40, 1), 1);
    check("c4160_grp_b67", bf(67, 1), 2);
    check("c4160_row1_ar", af(5, 0), 64'h1000);

    run_case("c4096", 32'h0, 4096, 1, 32'h0, 1'b0, -1, 1'b0);
    check("c4096_beats", 64'(obs_beat.size()), 66);
    check("c4096_scales", 64'(scale_count(66)), 2);
    check("c4096_scale65_last", bf(65, 3), 1);

    run_case("c4k", 32'hFC0, 704, 1, 32'h0, 1'b0, -1, 1'b0);
    check("c4k_ar0_addr", af(0, 0), 64'hFC0);
    check("c4k_ar0_len", af(0, 1), 1);
    check("c4k_ar1_addr", af(1, 0), 64'h1000);
    check("c4k_ar1_len", af(1, 1), 9);

    run_case("c700", 32'h0, 700, 1, 32'h0, 1'b0, -1, 1'b1);
    run_case("rows0", 32'h0, 704, 0, 32'h0, 1'b0, -1, 1'b0);
    run_case("misalign", 32'h10, 704, 1, 32'h0, 1'b0, -1, 1'b1);
    run_case("stall_err", 32'hF00, 4160, 2, 32'h1000, 1'b1, 5, 1'b0);
    run_case("multi", 32'hF00, 2048, 3, 32'h820, 1'b1, -1, 1'b0);

    // reset in the middle of a stalled run
    build_exp(32'h0, 4160, 2, 32'h1000);
    acc_cnt  = 0;
    err_beat = 3;
    stall    = 1'b1;
    issue_start(32'h0, 4160, 2, 32'h1000);
    reached = 1'b0;
    for (int i = 0; i < 5000 && !reached; i++) begin
      @(negedge clk);
      #3;
      if (acc_cnt >= 20) reached = 1'b1;
    end
    check("rst_mid_reached", 64'(reached), 1);
    check("rst_mid_busy_before", 64'(busy), 1);
    check("rst_mid_err_resp_before", 64'(err_resp), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    stall = 1'b0;
    exp_beat.delete();
    exp_ar.delete();
    @(negedge clk);
    #3;
    check("rst_mid_busy", 64'(busy), 0);
    check("rst_mid_arvalid", 64'(arvalid), 0);
    check("rst_mid_done", 64'(done), 0);
    check("rst_mid_errs", 64'({err_cfg, err_resp}), 0);
    check("rst_mid_tags", 64'({out_is_scale, out_row_last, out_last, out_group}), 0);
    check("rst_mid_rready", 64'(rready), 64'(out_ready));
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    run_case("post_rst", 32'h0, 704, 1, 32'h0, 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
